// File: rtl/fle_frac_lut_cfg.sv
// Fracturable logic element: one K-input LUT, splittable into two (K-1)-input
// LUTs that share inputs, with two optional output registers. The configuration
// frame (mask plus mode bits) shifts in serially on the user clock.
module fle_frac_lut_cfg #(
   parameter int unsigned K = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         prog_en,
   input  logic         ccff_head,
   output logic         ccff_tail,
   input  logic         ce,
   input  logic [K-1:0] fle_in,
   output logic [1:0]   fle_out,
   output logic         cfg_valid
);

   localparam int unsigned M     = 2**K;
   localparam int unsigned CFG_W = M + 3;
   localparam int unsigned CNT_W = $clog2(CFG_W + 1);

   generate
      if (K < 3 || K > 6) begin : g_bad_k
         $error("fle_frac_lut_cfg: K must be in 3..6");
      end
   endgenerate

   logic [CFG_W-1:0] cfg;
   logic [CNT_W-1:0] cnt;
   logic [M-1:0]     mask;
   logic             frac;
   logic             bypass0;
   logic             bypass1;
   logic [K-1:0]     idx0;
   logic [K-1:0]     idx1;
   logic             lut0;
   logic             lut1;
   logic             ff0;
   logic             ff1;

   assign mask    = cfg[M-1:0];
   assign frac    = cfg[M];
   assign bypass0 = cfg[M+1];
   assign bypass1 = cfg[M+2];

   // Config chain: shift MSB-first while programming; tail is a register bit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cfg <= '0;
      end else if (prog_en) begin
         cfg <= {cfg[CFG_W-2:0], ccff_head};
      end
   end

   // Saturating shift counter; only reset clears it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (prog_en && (cnt != CNT_W'(CFG_W))) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Mask lookup: in fractured mode the top input selects the mask half
   // per output, so lut1 always reads the upper half and lut0 the lower.
   always_comb begin
      idx0 = fle_in;
      idx1 = fle_in;
      if (frac) begin
         idx0 = {1'b0, fle_in[K-2:0]};
         idx1 = {1'b1, fle_in[K-2:0]};
      end
      lut0 = mask[idx0];
      lut1 = mask[idx1];
   end

   // User output registers: capture only in user mode with clock enable.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ff0 <= 1'b0;
         ff1 <= 1'b0;
      end else if (!prog_en && ce) begin
         ff0 <= lut0;
         ff1 <= lut1;
      end
   end

   assign ccff_tail  = cfg[CFG_W-1];
   assign cfg_valid  = (cnt == CNT_W'(CFG_W)) && !prog_en;
   assign fle_out[0] = prog_en ? 1'b0 : (bypass0 ? lut0 : ff0);
   assign fle_out[1] = prog_en ? 1'b0 : (bypass1 ? lut1 : ff1);

endmodule

// File: doc/fle_frac_lut_cfg.md
Name: fle_frac_lut_cfg

Overview:
- Parametrised next-generation fracturable logic element (FLE) for the CLB: one K-input LUT, fracturable into two (K-1)-input LUTs sharing inputs, with two optional output registers.
- The configuration chain (LUT mask plus mode bits) is held locally and shifted in on the user clock under a program enable.
- A saturating shift counter reports when a full frame has been loaded.
- Intended to be instantiated N times per CLB, daisy-chained head-to-tail.

Parameters:
- K, 4, LUT input count; legal range 3..6.
- CFG_W, 2**K+3 (derived, not overridable), configuration chain length in bits.

Ports:
- clk  input  1  sole clock; config shift and user FFs, rising edge.
- reset  input  1  asynchronous, active-low reset.
- prog_en  input  1  1 = shift the config chain and suppress user logic.
- ccff_head  input  1  serial config input.
- ccff_tail  output  1  serial config output, equal to cfg[CFG_W-1].
- ce  input  1  user FF clock enable.
- fle_in  input  K  LUT inputs; fle_in[0] is the LSB of the mask index.
- fle_out  output  2  fle_out[0] is output 0, fle_out[1] is output 1.
- cfg_valid  output  1  full frame loaded and programming finished.

Behaviour:
- Config register cfg[CFG_W-1:0]:
  - cfg[2**K-1:0] is the LUT mask.
  - cfg[2**K] is frac.
  - cfg[2**K+1] is bypass0.
  - cfg[2**K+2] is bypass1.
- Shift: on a clk rise with prog_en=1, cfg <= {cfg[CFG_W-2:0], ccff_head}. Load order is MSB first (bypass1 first, mask bit 0 last).
- ccff_tail = cfg[CFG_W-1], a registered value with no combinational head-to-tail path.
- Shift counter cnt, width clog2(CFG_W+1):
  - Increments on each shift; saturates at CFG_W.
  - Clears on reset only; a prog_en deassert does not clear it. Reloading requires reset.
- cfg_valid = (cnt==CFG_W) & ~prog_en. It is combinational from registers.
- LUT evaluation, with idx = fle_in as an unsigned value:
  - frac=0: lut0 = mask[idx]; lut1 = lut0.
  - frac=1: lut0 = mask[idx[K-2:0]]; lut1 = mask[2**(K-1) + idx[K-2:0]]. fle_in[K-1] is ignored.
- User FFs ff0 and ff1:
  - On a clk rise with prog_en=0 and ce=1: ffN <= lutN.
  - Otherwise they hold.
  - No initial-value config; they are cleared by reset only.
- Outputs:
  - fle_out[N] = prog_en ? 0 : (bypassN ? lutN : ffN).
  - Combinational output latency is 0 cycles; registered output latency is 1 cycle after ce=1.
- Reset (reset=0, asynchronous, any time including mid-shift): cfg=0, cnt=0, ff0=ff1=0, so fle_out=2'b00, ccff_tail=0, cfg_valid=0.
  - The shift or capture on the edge during reset assertion is discarded.
  - Release is synchronous to the next clk rise.
- prog_en=1 and ce=1 together: the shift proceeds, the FFs hold, and the outputs are forced to 0.
- prog_en asserted again after a full load: shifting resumes and cnt stays saturated. The frame is then corrupted by design; software must reset before reloading.
- Expected size: 120-400 lines of RTL. The mask mux is generated from K; no hard-coded K=4 logic.

Test Plan:
1. Power-on: reset=0 with random fle_in/ccff_head/prog_en -> fle_out=00, ccff_tail=0, cfg_valid=0. Release, hold prog_en=0 for 5 cycles -> fle_out stays 00.
2. K=4 (CFG_W=19) combinational AND4: shift bypass1=0, bypass0=1, frac=0, mask=16'h8000 MSB first over 19 cycles, then prog_en=0.
   - cfg_valid=1.
   - fle_in=4'hF -> fle_out[0]=1 in the same cycle.
   - fle_in=4'hE -> fle_out[0]=0.
   - fle_out[1]=ff1=0 throughout.
3. Registered mode: same mask with bypass0=0 and ce=1; fle_in 4'hE->4'hF at edge t.
   - fle_out[0] goes to 1 after edge t+1.
   - With ce=0, fle_in back to 4'hE -> fle_out[0] holds 1.
4. Fracture: frac=1, bypass0=bypass1=1, mask=16'h9680 (upper XOR3, lower AND3).
   - fle_in=x111 -> 11.
   - x011 -> 00.
   - x001 -> fle_out[1]=1, fle_out[0]=0.
   - fle_in[3] toggling has no effect.
5. Chain passthrough: 20 shifts with first bit=1 and the rest 0 -> ccff_tail=1 after shift 19, 0 after shift 20; cnt saturated, cfg_valid=1 after prog_en=0. During shifting, fle_out=00.
6. Mid-shift reset: 10 ones shifted, then reset=0 pulsed between edges -> cfg=0, ccff_tail=0 immediately; a reload of 19 bits then yields cfg_valid=1 only after 19 new shifts.
